// File: rtl/region_proxy.sv
`default_nettype none
// ============================================================================
// Module   : region_proxy
// Function : Per-region request buffer, operator reconfiguration sequencer
//            and status-word generator for one reconfigurable region.
// Revision : 1.0  initial release
// ============================================================================
module region_proxy #(
    parameter int HTTP_META_WIDTH   = 98,
    parameter int OPERATOR_ID_WIDTH = 16,
    parameter int QDEPTH            = 16,
    parameter int MAX_INFLIGHT      = 4,
    parameter int LOAD_BITS         = $clog2(QDEPTH)
) (
    input  logic                           aclk,
    input  logic                           aresetn,

    input  logic [HTTP_META_WIDTH-1:0]     meta_in_tdata,
    input  logic                           meta_in_tvalid,
    output logic                           meta_in_tready,

    output logic [HTTP_META_WIDTH-1:0]     meta_out_tdata,
    output logic                           meta_out_tvalid,
    input  logic                           meta_out_tready,

    input  logic                           op_done,
    output logic                           reconfig_req,
    output logic [OPERATOR_ID_WIDTH-1:0]   reconfig_oid,
    input  logic                           reconfig_done,

    output logic [2*OPERATOR_ID_WIDTH-1:0] status_out,
    output logic                           err
);

    localparam int c_addr_w   = $clog2(QDEPTH);
    localparam int c_cnt_w    = c_addr_w + 1;
    localparam int c_ifl_w    = 4;
    localparam int c_sum_w    = ((c_cnt_w > c_ifl_w) ? c_cnt_w : c_ifl_w) + 1;
    localparam int c_load_max = (1 << LOAD_BITS) - 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_DRAIN    = 2'd2,
        S_RECONFIG = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [HTTP_META_WIDTH-1:0]      r_mem [QDEPTH];
    logic [c_addr_w-1:0]             r_wr_ptr;
    logic [c_addr_w-1:0]             r_rd_ptr;
    logic [c_cnt_w-1:0]              r_count;
    logic [c_ifl_w-1:0]              r_in_flight;
    logic [OPERATOR_ID_WIDTH-1:0]    r_cur_oid;
    logic                            r_cur_valid;
    logic                            r_err;
    logic [2*OPERATOR_ID_WIDTH-1:0]  r_status;

    logic                            w_ready;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_dec;
    logic                            w_empty;
    logic                            w_issue;
    logic                            w_reconfig;
    logic [HTTP_META_WIDTH-1:0]      w_head;
    logic [OPERATOR_ID_WIDTH-1:0]    w_head_oid;
    logic [c_sum_w-1:0]              w_sum;
    logic [LOAD_BITS-1:0]            w_load;
    logic [2*OPERATOR_ID_WIDTH-1:0]  w_status;

    assign w_ready    = (r_count < c_cnt_w'(QDEPTH));
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_oid = w_head[OPERATOR_ID_WIDTH-1:0];
    assign w_push     = meta_in_tvalid & w_ready;
    assign w_pop      = w_issue & meta_out_tready;
    // A completion with nothing outstanding is a protocol error, never a decrement.
    assign w_dec      = op_done & (r_in_flight != '0);

    // ---------------- FSM ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_reconfig  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (r_cur_valid && (w_head_oid == r_cur_oid)) begin
                        if (r_in_flight < c_ifl_w'(MAX_INFLIGHT)) begin
                            w_state_nxt = S_ISSUE;
                        end
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (meta_out_tready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (r_in_flight == '0) begin
                    w_state_nxt = S_RECONFIG;
                end
            end
            S_RECONFIG: begin
                w_reconfig = 1'b1;
                if (reconfig_done) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- request buffer ----------------
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= meta_in_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- in-flight, operator tracking, error ----------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_in_flight <= '0;
            r_cur_oid   <= '0;
            r_cur_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case ({w_pop, w_dec})
                2'b10:   r_in_flight <= r_in_flight + c_ifl_w'(1);
                2'b01:   r_in_flight <= r_in_flight - c_ifl_w'(1);
                default: r_in_flight <= r_in_flight;
            endcase
            // The region is undefined while being rewritten; only done restores validity.
            if (r_state == S_RECONFIG) begin
                if (reconfig_done) begin
                    r_cur_oid   <= w_head_oid;
                    r_cur_valid <= 1'b1;
                end else begin
                    r_cur_valid <= 1'b0;
                end
            end
            if ((op_done && (r_in_flight == '0)) ||
                (reconfig_done && (r_state != S_RECONFIG))) begin
                r_err <= 1'b1;
            end
        end
    end

    // ---------------- status word ----------------
    always_comb begin
        w_sum    = c_sum_w'(r_count) + c_sum_w'(r_in_flight);
        w_load   = (w_sum > c_sum_w'(c_load_max)) ? '1 : LOAD_BITS'(w_sum);
        w_status = '0;
        w_status[LOAD_BITS-1:0]                    = w_load;
        w_status[LOAD_BITS +: OPERATOR_ID_WIDTH]   = r_cur_oid;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_status <= '0;
        end else begin
            r_status <= w_status;
        end
    end

    // ---------------- outputs ----------------
    assign meta_in_tready  = w_ready;
    assign meta_out_tvalid = w_issue;
    assign meta_out_tdata  = w_issue ? w_head : '0;
    assign reconfig_req    = w_reconfig;
    assign reconfig_oid    = w_reconfig ? w_head_oid : '0;
    assign status_out      = r_status;
    assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_region_proxy.sv
`default_nettype none
// ============================================================================
// Module   : tb_region_proxy
// Function : Self-checking bench for region_proxy: directed scenarios plus a
//            randomized run against a transaction-level scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_region_proxy;

    localparam int W    = 98;
    localparam int OIDW = 16;
    localparam int QD   = 16;
    localparam int MAXI = 4;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [W-1:0]    meta_in_tdata = '0;
    logic            meta_in_tvalid = 1'b0;
    logic            meta_in_tready;
    logic [W-1:0]    meta_out_tdata;
    logic            meta_out_tvalid;
    logic            meta_out_tready = 1'b0;
    logic            op_done = 1'b0;
    logic            reconfig_req;
    logic [OIDW-1:0] reconfig_oid;
    logic            reconfig_done = 1'b0;
    logic [31:0]     status_out;
    logic            err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc[$];
    logic [W-1:0] last_meta;

    region_proxy #(
        .HTTP_META_WIDTH(W), .OPERATOR_ID_WIDTH(OIDW), .QDEPTH(QD), .MAX_INFLIGHT(MAXI)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .meta_in_tdata(meta_in_tdata), .meta_in_tvalid(meta_in_tvalid), .meta_in_tready(meta_in_tready),
        .meta_out_tdata(meta_out_tdata), .meta_out_tvalid(meta_out_tvalid), .meta_out_tready(meta_out_tready),
        .op_done(op_done), .reconfig_req(reconfig_req), .reconfig_oid(reconfig_oid),
        .reconfig_done(reconfig_done), .status_out(status_out), .err(err)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;
    // Handshakes are recorded mid-cycle; the transfer happens at the following rising edge.
    always @(negedge aclk) if (meta_out_tvalid && meta_out_tready) hs_cyc.push_back(cyc);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status(int cnt, int infl, logic [15:0] oid);
        int l;
        l = cnt + infl;
        if (l > 15) l = 15;
        return {12'b0, oid, 4'(l)};
    endfunction

    function automatic logic [W-1:0] rand_meta(logic [15:0] oid);
        logic [W-1:0] d;
        d = W'({$urandom(), $urandom(), $urandom(), $urandom()});
        d[15:0] = oid;
        return d;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        meta_in_tvalid = 1'b0;
        meta_in_tdata = '0;
        meta_out_tready = 1'b0;
        op_done = 1'b0;
        reconfig_done = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        hs_cyc.delete();
    endtask

    task automatic push_req(input logic [15:0] oid);
        int n;
        n = 0;
        last_meta = rand_meta(oid);
        meta_in_tdata = last_meta;
        meta_in_tvalid = 1'b1;
        while (!meta_in_tready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!meta_in_tready) begin
            failures++;
            $display("FAIL push_accept: tready=%0b after %0d cycles, required 1", meta_in_tready, n);
        end
        tick();
        meta_in_tvalid = 1'b0;
    endtask

    task automatic wait_reconfig();
        int n;
        n = 0;
        while (!reconfig_req && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!reconfig_req) begin
            failures++;
            $display("FAIL reconfig_wait: reconfig_req=%0b after %0d cycles, required 1", reconfig_req, n);
        end
    endtask

    task automatic pulse_op_done();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
    endtask

    task automatic pulse_reconfig_done();
        reconfig_done = 1'b1;
        tick();
        reconfig_done = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (meta_in_tready !== 1'b1) begin failures++; $display("FAIL rst_tready: got %0b need 1", meta_in_tready); end
        checks++; if (meta_out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %0b need 0", meta_out_tvalid); end
        checks++; if (meta_out_tdata !== '0) begin failures++; $display("FAIL rst_tdata: got %0h need 0", meta_out_tdata); end
        checks++; if (reconfig_req !== 1'b0) begin failures++; $display("FAIL rst_reconfig_req: got %0b need 0", reconfig_req); end
        checks++; if (reconfig_oid !== '0) begin failures++; $display("FAIL rst_reconfig_oid: got %0h need 0", reconfig_oid); end
        checks++; if (status_out !== '0) begin failures++; $display("FAIL rst_status: got %0h need 0", status_out); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b need 0", err); end
    endtask

    task automatic test_first_request();
        do_reset();
        meta_out_tready = 1'b1;
        push_req(16'h0005);
        wait_reconfig();
        checks++; if (reconfig_oid !== 16'h0005) begin failures++; $display("FAIL first_reconfig_oid: got %0h need 5", reconfig_oid); end
        checks++; if (meta_out_tvalid !== 1'b0) begin failures++; $display("FAIL first_no_issue: tvalid=%0b need 0", meta_out_tvalid); end
        checks++; if (status_out !== exp_status(1, 0, 16'h0)) begin failures++; $display("FAIL first_status_queued: got %0h need %0h", status_out, exp_status(1, 0, 16'h0)); end
        pulse_reconfig_done();
        checks++; if (meta_out_tvalid !== 1'b1 || reconfig_req !== 1'b0) begin failures++; $display("FAIL first_issue: tvalid=%0b req=%0b need 1/0", meta_out_tvalid, reconfig_req); end
        checks++; if (meta_out_tdata !== last_meta) begin failures++; $display("FAIL first_tdata: got %0h need %0h", meta_out_tdata, last_meta); end
        tick();
        tick();
        checks++; if (status_out !== exp_status(0, 1, 16'h5)) begin failures++; $display("FAIL first_status_busy: got %0h need %0h", status_out, exp_status(0, 1, 16'h5)); end
        pulse_op_done();
        tick();
        checks++; if (status_out !== exp_status(0, 0, 16'h5)) begin failures++; $display("FAIL first_status_idle: got %0h need %0h", status_out, exp_status(0, 0, 16'h5)); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL first_err: got %0b need 0", err); end
    endtask

    // Runs on from test_first_request: oid 5 loaded, nothing outstanding.
    task automatic test_back_to_back();
        hs_cyc.delete();
        push_req(16'h0005);
        push_req(16'h0005);
        push_req(16'h0005);
        wait_ticks(10);
        checks++; if (hs_cyc.size() !== 3) begin failures++; $display("FAIL b2b_count: got %0d issues need 3", hs_cyc.size()); end
        if (hs_cyc.size() == 3) begin
            checks++; if (hs_cyc[1] - hs_cyc[0] !== 2) begin failures++; $display("FAIL b2b_gap0: got %0d need 2", hs_cyc[1] - hs_cyc[0]); end
            checks++; if (hs_cyc[2] - hs_cyc[1] !== 2) begin failures++; $display("FAIL b2b_gap1: got %0d need 2", hs_cyc[2] - hs_cyc[1]); end
        end
        checks++; if (status_out !== exp_status(0, 3, 16'h5)) begin failures++; $display("FAIL b2b_load3: got %0h need %0h", status_out, exp_status(0, 3, 16'h5)); end
        op_done = 1'b1;
        wait_ticks(3);
        op_done = 1'b0;
        tick();
        checks++; if (status_out !== exp_status(0, 0, 16'h5)) begin failures++; $display("FAIL b2b_load0: got %0h need %0h", status_out, exp_status(0, 0, 16'h5)); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %0b need 0", err); end
    endtask

    task automatic test_inflight_limit();
        do_reset();
        meta_out_tready = 1'b1;
        repeat (6) push_req(16'h0005);
        wait_reconfig();
        pulse_reconfig_done();
        wait_ticks(20);
        checks++; if (hs_cyc.size() !== MAXI) begin failures++; $display("FAIL limit_issued: got %0d need %0d", hs_cyc.size(), MAXI); end
        checks++; if (status_out !== exp_status(2, 4, 16'h5)) begin failures++; $display("FAIL limit_load: got %0h need %0h", status_out, exp_status(2, 4, 16'h5)); end
        hs_cyc.delete();
        pulse_op_done();
        wait_ticks(2);
        checks++; if (hs_cyc.size() !== 1) begin failures++; $display("FAIL limit_fifth: got %0d issues need 1", hs_cyc.size()); end
    endtask

    task automatic test_oid_switch();
        bit seen;
        do_reset();
        meta_out_tready = 1'b1;
        push_req(16'h0005);
        push_req(16'h0005);
        wait_reconfig();
        pulse_reconfig_done();
        wait_ticks(8);
        checks++; if (hs_cyc.size() !== 2) begin failures++; $display("FAIL switch_inflight: got %0d issues need 2", hs_cyc.size()); end
        push_req(16'h0009);
        seen = 1'b0;
        repeat (10) begin tick(); if (reconfig_req) seen = 1'b1; end
        pulse_op_done();
        if (reconfig_req) seen = 1'b1;
        repeat (5) begin tick(); if (reconfig_req) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL switch_early_req: seen=%0b need 0", seen); end
        pulse_op_done();
        wait_reconfig();
        checks++; if (reconfig_oid !== 16'h0009) begin failures++; $display("FAIL switch_oid: got %0h need 9", reconfig_oid); end
        checks++; if (status_out[19:4] !== 16'h0005) begin failures++; $display("FAIL switch_status_old: got %0h need 5", status_out[19:4]); end
        pulse_reconfig_done();
        checks++; if (status_out[19:4] !== 16'h0005) begin failures++; $display("FAIL switch_status_lag: got %0h need 5", status_out[19:4]); end
        tick();
        checks++; if (status_out[19:4] !== 16'h0009) begin failures++; $display("FAIL switch_status_new: got %0h need 9", status_out[19:4]); end
    endtask

    task automatic test_full();
        bit opened;
        do_reset();
        meta_out_tready = 1'b0;
        repeat (QD) push_req(16'h0005);
        checks++; if (meta_in_tready !== 1'b0) begin failures++; $display("FAIL full_tready: got %0b need 0", meta_in_tready); end
        tick();
        checks++; if (status_out !== exp_status(QD, 0, 16'h0)) begin failures++; $display("FAIL full_load_sat: got %0h need %0h", status_out, exp_status(QD, 0, 16'h0)); end
        meta_in_tdata = rand_meta(16'h0005);
        meta_in_tvalid = 1'b1;
        opened = 1'b0;
        repeat (5) begin tick(); if (meta_in_tready) opened = 1'b1; end
        checks++; if (opened !== 1'b0) begin failures++; $display("FAIL full_held_off: tready seen=%0b need 0", opened); end
        checks++; if (reconfig_req !== 1'b1) begin failures++; $display("FAIL full_reconfig: got %0b need 1", reconfig_req); end
        pulse_reconfig_done();
        meta_out_tready = 1'b1;
        checks++; if (meta_in_tready !== 1'b0) begin failures++; $display("FAIL full_pop_cycle: tready=%0b need 0", meta_in_tready); end
        tick();
        checks++; if (meta_in_tready !== 1'b1) begin failures++; $display("FAIL full_after_pop: tready=%0b need 1", meta_in_tready); end
        tick();
        meta_in_tvalid = 1'b0;
        meta_out_tready = 1'b0;
        checks++; if (meta_in_tready !== 1'b0) begin failures++; $display("FAIL full_refill: tready=%0b need 0", meta_in_tready); end
    endtask

    task automatic test_err_reset();
        do_reset();
        pulse_op_done();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_opdone: got %0b need 1", err); end
        wait_ticks(3);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0b need 1", err); end
        checks++; if (status_out !== '0) begin failures++; $display("FAIL err_inflight: status=%0h need 0", status_out); end
        do_reset();
        pulse_reconfig_done();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_stray_done: got %0b need 1", err); end
        do_reset();
        push_req(16'h0007);
        wait_reconfig();
        pulse_op_done();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_in_reconfig: got %0b need 1", err); end
        aresetn = 1'b0;
        tick();
        checks++; if (reconfig_req !== 1'b0) begin failures++; $display("FAIL rstmid_req: got %0b need 0", reconfig_req); end
        checks++; if (status_out !== '0) begin failures++; $display("FAIL rstmid_status: got %0h need 0", status_out); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err: got %0b need 0", err); end
        aresetn = 1'b1;
        push_req(16'h0007);
        wait_reconfig();
        checks++; if (reconfig_oid !== 16'h0007) begin failures++; $display("FAIL rstmid_again: got %0h need 7", reconfig_oid); end
        pulse_reconfig_done();
        tick();
        pulse_op_done();
    endtask

    // Scoreboard: FIFO order, operator in effect, and outstanding work tracked as transactions.
    task automatic test_random();
        logic [W-1:0]  q[$];
        logic [W-1:0]  in_d;
        logic [31:0]   exp_st;
        logic [15:0]   cur;
        logic [15:0]   rc_oid;
        logic [15:0]   oid_pick;
        int            infl;
        int            i;
        bit            have_exp, f_push, f_pop, f_opd, f_rcd, fin;
        do_reset();
        q.delete();
        infl = 0; cur = 16'h0; i = 0; oid_pick = 16'h0005; in_d = '0; rc_oid = '0;
        have_exp = 0; f_push = 0; f_pop = 0; f_opd = 0; f_rcd = 0; fin = 0;
        while (!fin) begin
            tick();
            if (f_opd && infl > 0) infl--;
            if (f_pop) begin void'(q.pop_front()); infl++; end
            if (f_push) q.push_back(in_d);
            if (f_rcd) cur = rc_oid;
            if (have_exp) begin
                checks++; if (status_out !== exp_st) begin failures++; $display("FAIL rnd_status cyc %0d: got %0h need %0h", cyc, status_out, exp_st); end
            end
            checks++; if (meta_in_tready !== (q.size() < QD)) begin failures++; $display("FAIL rnd_tready cyc %0d: got %0b need %0b", cyc, meta_in_tready, q.size() < QD); end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_err cyc %0d: got %0b need 0", cyc, err); end
            exp_st = exp_status(q.size(), infl, cur);
            have_exp = 1;

            if (!meta_in_tvalid || f_push) begin
                if (i < 400 && $urandom_range(1, 0) == 1) begin
                    if ($urandom_range(7, 0) == 0) oid_pick = ($urandom_range(1, 0) == 1) ? 16'h0009 : 16'h0003;
                    else if ($urandom_range(7, 0) == 0) oid_pick = 16'h0005;
                    meta_in_tdata = rand_meta(oid_pick);
                    meta_in_tvalid = 1'b1;
                end else begin
                    meta_in_tvalid = 1'b0;
                end
            end
            meta_out_tready = ($urandom_range(3, 0) != 0);
            op_done = (infl > 0) && ($urandom_range(2, 0) == 0);
            reconfig_done = reconfig_req && ($urandom_range(2, 0) == 0);
            #1;
            f_push = meta_in_tvalid && meta_in_tready;
            in_d   = meta_in_tdata;
            f_pop  = meta_out_tvalid && meta_out_tready;
            f_opd  = op_done;
            f_rcd  = reconfig_done && reconfig_req;
            rc_oid = reconfig_oid;
            if (meta_out_tvalid) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rnd_issue_empty cyc %0d: tvalid=1 with no queued request", cyc); end
                else if (meta_out_tdata !== q[0]) begin failures++; $display("FAIL rnd_tdata cyc %0d: got %0h need %0h", cyc, meta_out_tdata, q[0]); end
                checks++; if (meta_out_tdata[15:0] !== cur) begin failures++; $display("FAIL rnd_issue_oid cyc %0d: got %0h loaded %0h", cyc, meta_out_tdata[15:0], cur); end
            end
            if (reconfig_req) begin
                checks++; if (infl !== 0) begin failures++; $display("FAIL rnd_req_busy cyc %0d: in_flight %0d need 0", cyc, infl); end
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rnd_req_empty cyc %0d: reconfig with no queued request", cyc); end
                else if (reconfig_oid !== q[0][15:0]) begin failures++; $display("FAIL rnd_req_oid cyc %0d: got %0h need %0h", cyc, reconfig_oid, q[0][15:0]); end
            end
            i++;
            if (i >= 400 && q.size() == 0 && infl == 0 && !f_push && !f_pop) fin = 1;
            if (i >= 3000) begin
                checks++; failures++;
                $display("FAIL rnd_drain: queue %0d in_flight %0d not drained", q.size(), infl);
                fin = 1;
            end
        end
        meta_in_tvalid = 1'b0;
        op_done = 1'b0;
        reconfig_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_request();
        test_back_to_back();
        test_inflight_limit();
        test_oid_switch();
        test_full();
        test_err_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
